// File: rtl/rr_response_router.sv
// -----------------------------------------------------------------------------
// rr_response_router
//
// Return path of the round-robin PLM scheduler. Every kernel (bank/port pair)
// remembers which consumer it granted on each cycle. That tag is delayed by
// the PLM read latency, then the PLM output word (for a read) or a write
// acknowledge is steered to the granted consumer's response registers.
//
// Parameters
//   ADDR_WIDTH   request address width (informational, must match scheduler)
//   VALUE_WIDTH  data word width
//   NCONSUMERS   number of consumers
//   NBANKS       number of PLM banks
//   NPORTS       ports per bank (1 or 2)
//   PLM_LATENCY  PLM read latency in cycles (1..4)
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   grant_valid      [NKERNELS]        kernel issued an eligible request
//   grant_consumer   [NKERNELS][CID_W] consumer granted by each kernel
//   grant_wr         [NKERNELS]        granted request is a write
//   plm_outputs      [NKERNELS][VW]    PLM read data, PLM_LATENCY after grant
//   resp_valid       [NCONSUMERS]      one-cycle response strobe
//   resp_wr          [NCONSUMERS]      response is a write acknowledge
//   resp_data        [NCONSUMERS][VW]  read data, zero for write acks
//   collision        sticky: two kernels hit one consumer in a delivery cycle
//   bad_consumer     sticky: out-of-range consumer index seen on a grant
//   collision_count  saturating count of cycles with a collision
// -----------------------------------------------------------------------------
module rr_response_router #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int NBANKS      = 1,
  parameter int NPORTS      = 1,
  parameter int PLM_LATENCY = 1,
  localparam int CID_W      = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1,
  localparam int NKERNELS   = NBANKS * NPORTS
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NKERNELS-1:0]                    grant_valid,
  input  logic [NKERNELS-1:0][CID_W-1:0]         grant_consumer,
  input  logic [NKERNELS-1:0]                    grant_wr,
  input  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]   plm_outputs,
  output logic [NCONSUMERS-1:0]                  resp_valid,
  output logic [NCONSUMERS-1:0]                  resp_wr,
  output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data,
  output logic                                   collision,
  output logic                                   bad_consumer,
  output logic [7:0]                             collision_count
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (NPORTS < 1 || NPORTS > 2) begin : g_bad_nports
    $error("rr_response_router: NPORTS must be 1 or 2");
  end
  if (PLM_LATENCY < 1 || PLM_LATENCY > 4) begin : g_bad_latency
    $error("rr_response_router: PLM_LATENCY must be in 1..4");
  end
  if (NCONSUMERS < 1 || NBANKS < 1 || VALUE_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_bad_sizes
    $error("rr_response_router: NCONSUMERS, NBANKS, VALUE_WIDTH, ADDR_WIDTH must be >= 1");
  end

  // Tag leaving the last pipeline stage of each kernel; it lines up with the
  // PLM word currently on plm_outputs for that kernel.
  logic [NKERNELS-1:0]            dlv_valid;
  logic [NKERNELS-1:0][CID_W-1:0] dlv_cons;
  logic [NKERNELS-1:0]            dlv_wr;
  logic [NKERNELS-1:0]            grant_bad;

  // ---------------------------------------------------------------------------
  // Per-kernel tag pipeline
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NKERNELS; gi++) begin : g_kernel
    logic [PLM_LATENCY-1:0]            tag_valid_q, tag_valid_d;
    logic [PLM_LATENCY-1:0][CID_W-1:0] tag_cons_q, tag_cons_d;
    logic [PLM_LATENCY-1:0]            tag_wr_q, tag_wr_d;
    logic                              in_range;

    // When NCONSUMERS is a power of two this is constant true and folds away.
    assign in_range = (int'(grant_consumer[gi]) < NCONSUMERS);

    always_comb begin
      tag_valid_d = tag_valid_q;
      tag_cons_d  = tag_cons_q;
      tag_wr_d    = tag_wr_q;
      // Stage 0 reloads every clock; an out-of-range consumer becomes a
      // bubble so it can never reach a response register.
      tag_valid_d[0] = grant_valid[gi] & in_range;
      tag_cons_d[0]  = grant_consumer[gi];
      tag_wr_d[0]    = grant_wr[gi];
      for (int s = 1; s < PLM_LATENCY; s++) begin
        tag_valid_d[s] = tag_valid_q[s-1];
        tag_cons_d[s]  = tag_cons_q[s-1];
        tag_wr_d[s]    = tag_wr_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        tag_valid_q <= '0;
        tag_cons_q  <= '0;
        tag_wr_q    <= '0;
      end else begin
        tag_valid_q <= tag_valid_d;
        tag_cons_q  <= tag_cons_d;
        tag_wr_q    <= tag_wr_d;
      end
    end

    assign dlv_valid[gi] = tag_valid_q[PLM_LATENCY-1];
    assign dlv_cons[gi]  = tag_cons_q[PLM_LATENCY-1];
    assign dlv_wr[gi]    = tag_wr_q[PLM_LATENCY-1];
    assign grant_bad[gi] = grant_valid[gi] & ~in_range;
  end

  // ---------------------------------------------------------------------------
  // Per-consumer delivery selection
  // ---------------------------------------------------------------------------
  logic [NCONSUMERS-1:0]                  resp_valid_d, resp_valid_q;
  logic [NCONSUMERS-1:0]                  resp_wr_d, resp_wr_q;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data_d, resp_data_q;
  logic [NCONSUMERS-1:0]                  cons_clash;

  for (genvar gi = 0; gi < NCONSUMERS; gi++) begin : g_cons
    logic                   win_valid;
    logic                   win_wr;
    logic [VALUE_WIDTH-1:0] win_data;
    logic                   clash;

    // Scan kernels in ascending K_ID: the first delivering tag naming this
    // consumer wins, any later one only flags the clash and is dropped.
    always_comb begin
      win_valid = 1'b0;
      win_wr    = 1'b0;
      win_data  = '0;
      clash     = 1'b0;
      for (int k = 0; k < NKERNELS; k++) begin
        if (dlv_valid[k] && (int'(dlv_cons[k]) == gi)) begin
          if (win_valid) begin
            clash = 1'b1;
          end else begin
            win_valid = 1'b1;
            win_wr    = dlv_wr[k];
            win_data  = dlv_wr[k] ? '0 : plm_outputs[k];
          end
        end
      end
    end

    assign resp_valid_d[gi] = win_valid;
    assign resp_wr_d[gi]    = win_wr;
    assign resp_data_d[gi]  = win_data;
    assign cons_clash[gi]   = clash;
  end

  // ---------------------------------------------------------------------------
  // Sticky status
  // ---------------------------------------------------------------------------
  logic       collision_d, collision_q;
  logic       bad_consumer_d, bad_consumer_q;
  logic [7:0] collision_count_d, collision_count_q;
  logic       any_clash;

  always_comb begin
    any_clash         = |cons_clash;
    collision_d       = collision_q | any_clash;
    bad_consumer_d    = bad_consumer_q | (|grant_bad);
    collision_count_d = collision_count_q;
    // One increment per cycle however many consumers clashed; hold at 255.
    if (any_clash && (collision_count_q != 8'hFF)) begin
      collision_count_d = collision_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q      <= '0;
      resp_wr_q         <= '0;
      resp_data_q       <= '0;
      collision_q       <= 1'b0;
      bad_consumer_q    <= 1'b0;
      collision_count_q <= '0;
    end else begin
      resp_valid_q      <= resp_valid_d;
      resp_wr_q         <= resp_wr_d;
      resp_data_q       <= resp_data_d;
      collision_q       <= collision_d;
      bad_consumer_q    <= bad_consumer_d;
      collision_count_q <= collision_count_d;
    end
  end

  assign resp_valid      = resp_valid_q;
  assign resp_wr         = resp_wr_q;
  assign resp_data       = resp_data_q;
  assign collision       = collision_q;
  assign bad_consumer    = bad_consumer_q;
  assign collision_count = collision_count_q;

endmodule

// File: tb/tb_rr_response_router.sv
// -----------------------------------------------------------------------------
// tb_rr_response_router
//
// Two router instances share clock and reset:
//   dut0: NCONSUMERS=2, PLM_LATENCY=1, NBANKS=1, NPORTS=2 (2 kernels)
//   dut1: NCONSUMERS=3, PLM_LATENCY=3, NBANKS=2, NPORTS=1 (2 kernels)
// Inputs are recorded at every rising edge. A reference model derives the
// expected outputs from that history: the response seen after edge n comes
// from the grant made PLM_LATENCY edges earlier, lowest kernel wins, with
// grants older than the latest reset ignored. Directed scenarios add literal
// expectations on top of the per-cycle comparison.
// -----------------------------------------------------------------------------
module tb_rr_response_router;

  localparam int MAXE = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Stimulus per instance: 2 kernels, consumer field 2 bits per kernel.
  logic [1:0]  gv  [2];
  logic [3:0]  gc  [2];
  logic [1:0]  gw  [2];
  logic [15:0] plm [2];

  // Observed outputs, zero-extended to 3 consumers.
  logic [2:0]  rv   [2];
  logic [2:0]  rw   [2];
  logic [23:0] rd   [2];
  logic        col  [2];
  logic        bad  [2];
  logic [7:0]  ccnt [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int NC  = (gi == 0) ? 2 : 3;
    localparam int LAT = (gi == 0) ? 1 : 3;
    localparam int CW  = (gi == 0) ? 1 : 2;
    localparam int NB  = (gi == 0) ? 1 : 2;
    localparam int NP  = (gi == 0) ? 2 : 1;

    logic [1:0][CW-1:0] gc_i;
    logic [NC-1:0]      rv_i, rw_i;
    logic [NC-1:0][7:0] rd_i;
    logic               col_i, bad_i;
    logic [7:0]         cc_i;

    for (genvar gk = 0; gk < 2; gk++) begin : g_k
      assign gc_i[gk] = gc[gi][gk*2 +: CW];
    end

    rr_response_router #(
      .ADDR_WIDTH (4),
      .VALUE_WIDTH(8),
      .NCONSUMERS (NC),
      .NBANKS     (NB),
      .NPORTS     (NP),
      .PLM_LATENCY(LAT)
    ) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .grant_valid    (gv[gi]),
      .grant_consumer (gc_i),
      .grant_wr       (gw[gi]),
      .plm_outputs    (plm[gi]),
      .resp_valid     (rv_i),
      .resp_wr        (rw_i),
      .resp_data      (rd_i),
      .collision      (col_i),
      .bad_consumer   (bad_i),
      .collision_count(cc_i)
    );

    assign rv[gi]   = 3'(rv_i);
    assign rw[gi]   = 3'(rw_i);
    assign rd[gi]   = 24'(rd_i);
    assign col[gi]  = col_i;
    assign bad[gi]  = bad_i;
    assign ccnt[gi] = cc_i;
  end

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input int inst, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h, required %0h (t=%0t)", inst, name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Input history
  // ---------------------------------------------------------------------------
  logic [1:0]  h_gv  [2][MAXE];
  logic [3:0]  h_gc  [2][MAXE];
  logic [1:0]  h_gw  [2][MAXE];
  logic [15:0] h_plm [2][MAXE];
  logic        h_rst [MAXE];
  int          edge_cnt = 0;
  int          rst_mark = 0;  // first edge index not discarded by a reset

  always @(posedge clk) begin
    if (edge_cnt < MAXE) begin
      for (int i = 0; i < 2; i++) begin
        h_gv[i][edge_cnt]  <= gv[i];
        h_gc[i][edge_cnt]  <= gc[i];
        h_gw[i][edge_cnt]  <= gw[i];
        h_plm[i][edge_cnt] <= plm[i];
      end
      h_rst[edge_cnt] <= ~reset_n;
    end
    edge_cnt <= edge_cnt + 1;
  end

  initial begin
    forever begin
      @(negedge reset_n);
      rst_mark = edge_cnt;
    end
  end

  function automatic int cons_of(input int i, input int m, input int k);
    logic [3:0] word;
    logic [1:0] v;
    word = h_gc[i][m];
    v    = word[k*2 +: 2];
    if (i == 0) v[1] = 1'b0;  // dut0 only sees a 1-bit consumer index
    return int'(v);
  endfunction

  // Expected outputs visible after the most recent rising edge.
  task automatic model(input int i, output logic [2:0] ev, output logic [2:0] ew,
                       output logic [23:0] ed, output logic ecol, output logic ebad,
                       output logic [7:0] ecnt);
    int nc, lat, n, g, c, cc;
    int hits [3];
    nc = (i == 0) ? 2 : 3;
    lat = (i == 0) ? 1 : 3;
    ev = '0; ew = '0; ed = '0; ecol = 1'b0; ebad = 1'b0; cc = 0;
    n = edge_cnt - 1;
    if (reset_n === 1'b1) begin
      for (int m = rst_mark; m <= n; m++) begin
        if (!h_rst[m]) begin
          for (int k = 0; k < 2; k++)
            if (h_gv[i][m][k] && cons_of(i, m, k) >= nc) ebad = 1'b1;
          hits = '{0, 0, 0};
          g = m - lat;
          if (g >= rst_mark && !h_rst[g]) begin
            for (int k = 0; k < 2; k++) begin
              if (h_gv[i][g][k]) begin
                c = cons_of(i, g, k);
                if (c < nc) begin
                  if (hits[c] == 0 && m == n) begin
                    ev[c] = 1'b1;
                    ew[c] = h_gw[i][g][k];
                    ed[c*8 +: 8] = h_gw[i][g][k] ? 8'h00 : h_plm[i][m][k*8 +: 8];
                  end
                  hits[c]++;
                end
              end
            end
          end
          if (hits[0] > 1 || hits[1] > 1 || hits[2] > 1) begin
            ecol = 1'b1;
            if (cc < 255) cc++;
          end
        end
      end
    end
    ecnt = 8'(cc);
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  initial begin
    logic [2:0]  ev, ew;
    logic [23:0] ed;
    logic        ecol, ebad;
    logic [7:0]  ecnt;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model(i, ev, ew, ed, ecol, ebad, ecnt);
        chk(i, "resp_valid", 32'(rv[i]), 32'(ev));
        chk(i, "resp_wr", 32'(rw[i]), 32'(ew));
        chk(i, "resp_data", 32'(rd[i]), 32'(ed));
        chk(i, "collision", 32'(col[i]), 32'(ecol));
        chk(i, "bad_consumer", 32'(bad[i]), 32'(ebad));
        chk(i, "collision_count", 32'(ccnt[i]), 32'(ecnt));
        for (int c = 0; c < 3; c++)
          if (rv[i][c] === 1'b1)
            $display("resp dut%0d consumer=%0d wr=%0d data=%02h count=%0d",
                     i, c, rw[i][c], rd[i][c*8 +: 8], ccnt[i]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      gv[i] = '0; gc[i] = '0; gw[i] = '0; plm[i] = '0;
    end
  endtask

  initial begin
    idle();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk(i, "lit_reset_valid", 32'(rv[i]), 32'h0);
      chk(i, "lit_reset_count", 32'(ccnt[i]), 32'h0);
    end

    // dut0: kernel 0 reads for consumer 1
    gv[0] = 2'b01; gc[0] = 4'b0001; gw[0] = 2'b00;
    @(negedge clk);
    idle(); plm[0] = 16'h00A5;
    @(negedge clk);
    chk(0, "lit_read_valid", 32'(rv[0]), 32'h2);
    chk(0, "lit_read_data", 32'(rd[0][15:8]), 32'hA5);
    chk(0, "lit_read_wr", 32'(rw[0]), 32'h0);
    idle();
    @(negedge clk);
    chk(0, "lit_read_pulse_end", 32'(rv[0]), 32'h0);

    // dut0: kernel 1 writes for consumer 0, PLM data must be ignored
    gv[0] = 2'b10; gc[0] = 4'b0000; gw[0] = 2'b10;
    @(negedge clk);
    idle(); plm[0] = 16'h5A5A;
    @(negedge clk);
    chk(0, "lit_write_valid", 32'(rv[0]), 32'h1);
    chk(0, "lit_write_wr", 32'(rw[0]), 32'h1);
    chk(0, "lit_write_data", 32'(rd[0][7:0]), 32'h0);
    idle();
    @(negedge clk);

    // dut0: both kernels hit consumer 0, 300 cycles in a row
    gv[0] = 2'b11; gc[0] = 4'b0000; gw[0] = 2'b00; plm[0] = 16'h2211;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (t == 1) begin
        chk(0, "lit_coll_data", 32'(rd[0][7:0]), 32'h11);
        chk(0, "lit_coll_flag", 32'(col[0]), 32'h1);
        chk(0, "lit_coll_count1", 32'(ccnt[0]), 32'h1);
      end
    end
    idle();
    repeat (2) @(negedge clk);
    chk(0, "lit_coll_saturate", 32'(ccnt[0]), 32'hFF);

    // dut1: four back-to-back reads for consumer 1 on kernel 0, plus one
    // read for consumer 2 on kernel 1 delivered alongside the first
    for (int s = 0; s < 8; s++) begin
      idle();
      if (s < 4) begin
        gv[1] = (s == 0) ? 2'b11 : 2'b01;
        gc[1] = (s == 0) ? 4'b1001 : 4'b0001;
      end
      if (s >= 3 && s <= 6) plm[1][7:0] = 8'(s - 2);
      if (s == 3) plm[1][15:8] = 8'h77;
      @(negedge clk);
      if (s >= 3 && s <= 6) begin
        chk(1, "lit_pipe_valid", 32'(rv[1][1]), 32'h1);
        chk(1, "lit_pipe_data", 32'(rd[1][15:8]), 32'(s - 2));
      end
      if (s == 3) chk(1, "lit_pipe_k1_data", 32'(rd[1][23:16]), 32'h77);
      if (s == 7) chk(1, "lit_pipe_end", 32'(rv[1]), 32'h0);
    end
    chk(1, "lit_pipe_no_collision", 32'(col[1]), 32'h0);

    // dut1: out-of-range consumer index
    idle(); gv[1] = 2'b01; gc[1] = 4'b0011;
    @(negedge clk);
    idle();
    chk(1, "lit_bad_set", 32'(bad[1]), 32'h1);
    repeat (4) @(negedge clk);
    chk(1, "lit_bad_held", 32'(bad[1]), 32'h1);
    chk(1, "lit_bad_no_resp", 32'(rv[1]), 32'h0);

    // dut1: read in flight, reset pulsed one cycle after the grant
    gv[1] = 2'b01; gc[1] = 4'b0000;
    @(negedge clk);
    idle(); plm[1] = 16'hEEEE; plm[0] = 16'hEEEE;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(i, "lit_async_valid", 32'(rv[i]), 32'h0);
      chk(i, "lit_async_data", 32'(rd[i]), 32'h0);
      chk(i, "lit_async_coll", 32'(col[i]), 32'h0);
      chk(i, "lit_async_count", 32'(ccnt[i]), 32'h0);
      chk(i, "lit_async_bad", 32'(bad[i]), 32'h0);
    end
    #1 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk(1, "lit_flush_no_resp", 32'(rv[1]), 32'h0);

    idle();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
